// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW hazard detection for the decode stage.
// Tracks in-flight destinations in EX/MEM/WB, drives stall/issue/forward selects.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   id_valid             ID holds a real instruction
//   id_rs/id_rt          source registers, with id_rs_valid/id_rt_valid
//   id_wr_valid/wr_reg   destination write enable and register
//   id_is_load           ID instruction is a load
//   flush                kill the ID instruction (branch/jump taken)
//   mem_stall            freeze the whole pipeline
//   stall                hold PC and IF/ID, bubble into ID/EX
//   issue                ID instruction advances to EX this cycle
//   rs_fwd/rt_fwd        0 regfile, 1 EX/MEM, 2 MEM/WB
//   stall_cnt            saturating count of hazard-stall cycles
module hazard_scoreboard #(
    parameter bit FORWARDING = 1'b1,
    parameter bit WB_BYPASS  = 1'b1,
    parameter int REG_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_valid,
    input  logic             id_rt_valid,
    input  logic             id_wr_valid,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             mem_stall,
    output logic             stall,
    output logic             issue,
    output logic [1:0]       rs_fwd,
    output logic [1:0]       rt_fwd,
    output logic [15:0]      stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
    } ent_t;

    // Only the EX entry's load flag can cause a hazard, so it is the
    // only one kept; MEM/WB loads forward like any other producer.
    ent_t ex_q, mem_q, wb_q;
    logic ex_load_q;

    ent_t ex_d;
    logic ex_load_d;
    logic adv;
    logic cnt_inc;

    logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
    logic hit_ex, hit_mem, hit_wb;
    logic haz;

    assign rs_ex  = id_rs_valid & ex_q.valid  & (ex_q.dest  == id_rs);
    assign rt_ex  = id_rt_valid & ex_q.valid  & (ex_q.dest  == id_rt);
    assign rs_mem = id_rs_valid & mem_q.valid & (mem_q.dest == id_rs);
    assign rt_mem = id_rt_valid & mem_q.valid & (mem_q.dest == id_rt);
    assign rs_wb  = id_rs_valid & wb_q.valid  & (wb_q.dest  == id_rs);
    assign rt_wb  = id_rt_valid & wb_q.valid  & (wb_q.dest  == id_rt);

    assign hit_ex  = rs_ex  | rt_ex;
    assign hit_mem = rs_mem | rt_mem;
    assign hit_wb  = rs_wb  | rt_wb;

    // With forwarding only a load in EX is too late to bypass;
    // without it any producer not yet written back blocks the reader.
    assign haz = FORWARDING
        ? (id_valid & hit_ex & ex_load_q)
        : (id_valid & (hit_ex | hit_mem | (~WB_BYPASS & hit_wb)));

    always_comb begin
        stall     = 1'b0;
        issue     = 1'b0;
        adv       = 1'b1;
        cnt_inc   = 1'b0;
        ex_d      = '0;
        ex_load_d = 1'b0;
        if (mem_stall) begin
            stall = 1'b1;
            adv   = 1'b0;
        end else if (!flush) begin
            if (haz) begin
                stall   = 1'b1;
                cnt_inc = 1'b1;
            end else begin
                issue      = id_valid;
                ex_d.valid = id_valid & id_wr_valid;
                ex_d.dest  = id_wr_reg;
                ex_load_d  = id_is_load;
            end
        end
    end

    // Younger producer (EX) takes precedence over MEM.
    always_comb begin
        rs_fwd = 2'd0;
        rt_fwd = 2'd0;
        if (FORWARDING && issue) begin
            if (rs_ex)
                rs_fwd = 2'd1;
            else if (rs_mem)
                rs_fwd = 2'd2;
            if (rt_ex)
                rt_fwd = 2'd1;
            else if (rt_mem)
                rt_fwd = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_load_q <= 1'b0;
            stall_cnt <= 16'd0;
        end else if (adv) begin
            wb_q      <= mem_q;
            mem_q     <= ex_q;
            ex_q      <= ex_d;
            ex_load_q <= ex_load_d;
            if (cnt_inc && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
